// File: rtl/serial_io_loader.sv
// serial_io_loader: 8N1 UART receiver plus packet parser that loads the
// seven AGC input registers (VERB, NOUN, G, M, RA, RB, ATX).
// Ports:
//   clock, reset (sync, active-high)
//   rx_serial (async serial line, idles high)
//   dsky_verb, dsky_noun, axi_g, axi_m, axi_ra, axi_rb, axi_atx (15-bit regs)
//   pkt_valid, pkt_err (1-cycle pulses)
//   pkt_sel (last committed select)
//   rx_busy (receiver inside a character)
// Packet: SYNC, sel, hi, lo, chk where chk = sel ^ hi ^ lo.
module serial_io_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_serial,
  output logic [14:0] dsky_verb,
  output logic [14:0] dsky_noun,
  output logic [14:0] axi_g,
  output logic [14:0] axi_m,
  output logic [14:0] axi_ra,
  output logic [14:0] axi_rb,
  output logic [14:0] axi_atx,
  output logic        pkt_valid,
  output logic [2:0]  pkt_sel,
  output logic        pkt_err,
  output logic        rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    U_IDLE, U_START, U_DATA, U_STOP
  } ustate_t;

  typedef enum logic [2:0] {
    P_HUNT, P_SEL, P_HI, P_LO, P_CHK
  } pstate_t;

  logic [1:0]    r_sync;
  logic          w_rx;
  ustate_t       r_ustate;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic          r_byte_ok;
  logic          r_frm_err;
  logic          r_busy;

  pstate_t       r_pstate;
  logic [2:0]    r_sel;
  logic [6:0]    r_hi;
  logic [7:0]    r_lo;
  logic [14:0]   r_regs [7];
  logic          r_valid;
  logic          r_err;
  logic [2:0]    r_psel;
  logic [7:0]    w_sum;

  assign w_rx  = r_sync[1];
  assign w_sum = {5'd0, r_sel} ^ {1'b0, r_hi} ^ r_lo;

  // UART receiver; the byte stays in r_shreg until the next DATA state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_ustate  <= U_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shreg   <= '0;
      r_byte_ok <= 1'b0;
      r_frm_err <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rx_serial};
      r_byte_ok <= 1'b0;
      r_frm_err <= 1'b0;
      case (r_ustate)
        U_IDLE: begin
          if (!w_rx) begin
            r_ustate <= U_START;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        U_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            if (!w_rx) begin
              r_ustate <= U_DATA;
            end else begin
              r_ustate <= U_IDLE;
              r_busy   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_shreg <= {w_rx, r_shreg[7:1]};
            if (r_bit == 3'd7) r_ustate <= U_STOP;
            else r_bit <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == C_FULL) begin
            r_cnt     <= '0;
            r_ustate  <= U_IDLE;
            r_busy    <= 1'b0;
            r_byte_ok <= w_rx;
            r_frm_err <= !w_rx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Packet parser; steps once per received byte
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pstate <= P_HUNT;
      r_sel    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_psel   <= '0;
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_frm_err) begin
        r_err    <= 1'b1;
        r_pstate <= P_HUNT;
      end else if (r_byte_ok) begin
        case (r_pstate)
          P_HUNT: begin
            if (r_shreg == SYNC_BYTE) r_pstate <= P_SEL;
          end
          P_SEL: begin
            r_sel <= r_shreg[2:0];
            if (r_shreg > 8'd6) begin
              r_err    <= 1'b1;
              r_pstate <= P_HUNT;
            end else begin
              r_pstate <= P_HI;
            end
          end
          P_HI: begin
            r_hi <= r_shreg[6:0];
            if (r_shreg[7]) begin
              r_err    <= 1'b1;
              r_pstate <= P_HUNT;
            end else begin
              r_pstate <= P_LO;
            end
          end
          P_LO: begin
            r_lo     <= r_shreg;
            r_pstate <= P_CHK;
          end
          default: begin
            r_pstate <= P_HUNT;
            if (r_shreg == w_sum) begin
              r_valid <= 1'b1;
              r_psel  <= r_sel;
              for (int i = 0; i < 7; i++)
                if (r_sel == 3'(i)) r_regs[i] <= {r_hi, r_lo};
            end else begin
              r_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign dsky_verb = r_regs[0];
  assign dsky_noun = r_regs[1];
  assign axi_g     = r_regs[2];
  assign axi_m     = r_regs[3];
  assign axi_ra    = r_regs[4];
  assign axi_rb    = r_regs[5];
  assign axi_atx   = r_regs[6];
  assign pkt_valid = r_valid;
  assign pkt_err   = r_err;
  assign pkt_sel   = r_psel;
  assign rx_busy   = r_busy;

endmodule

// File: tb/tb_serial_io_loader.sv
// Testbench for serial_io_loader: byte-level packet model with an event
// queue, per-cycle output compare, literal pins and random packets.
module tb_serial_io_loader;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_serial = 1'b1;
  logic [14:0] dsky_verb, dsky_noun, axi_g, axi_m;
  logic [14:0] axi_ra, axi_rb, axi_atx;
  logic        pkt_valid, pkt_err, rx_busy;
  logic [2:0]  pkt_sel;

  always #5 clock = ~clock;

  serial_io_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .rx_serial(rx_serial),
    .dsky_verb(dsky_verb), .dsky_noun(dsky_noun),
    .axi_g(axi_g), .axi_m(axi_m), .axi_ra(axi_ra),
    .axi_rb(axi_rb), .axi_atx(axi_atx),
    .pkt_valid(pkt_valid), .pkt_sel(pkt_sel),
    .pkt_err(pkt_err), .rx_busy(rx_busy)
  );

  typedef struct {
    bit         is_err;
    logic [2:0] sel;
    logic [14:0] data;
  } ev_t;

  int          n_checks = 0;
  int          n_errors = 0;
  ev_t         evq[$];
  logic [7:0]  mbuf[$];
  logic [14:0] exp_reg [7];
  logic [2:0]  exp_sel = 3'd0;
  int          n_valid = 0;
  int          n_err = 0;
  bit          busy_seen = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors < 100)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Packet model: collects bytes from a sync byte onward and decides
  // the outcome by the packet rules, queuing the expected pulse.
  function automatic void model_byte(logic [7:0] b, bit frame_ok);
    ev_t e;
    e.is_err = 1'b1;
    e.sel = 3'd0;
    e.data = 15'd0;
    if (!frame_ok) begin
      evq.push_back(e);
      mbuf.delete();
      return;
    end
    if (mbuf.size() == 0) begin
      if (b == 8'hA5) mbuf.push_back(b);
      return;
    end
    mbuf.push_back(b);
    if (mbuf.size() == 2 && b > 8'd6) begin
      evq.push_back(e);
      mbuf.delete();
    end else if (mbuf.size() == 3 && b[7]) begin
      evq.push_back(e);
      mbuf.delete();
    end else if (mbuf.size() == 5) begin
      if ((mbuf[1] ^ mbuf[2] ^ mbuf[3]) == mbuf[4]) begin
        e.is_err = 1'b0;
        e.sel = mbuf[1][2:0];
        e.data = {mbuf[2][6:0], mbuf[3]};
      end
      evq.push_back(e);
      mbuf.delete();
    end
  endfunction

  // Compare process: every cycle out of reset
  ev_t ce;
  always @(negedge clock) begin
    if (!reset) begin
      if (pkt_valid) n_valid++;
      if (pkt_err) n_err++;
      if (pkt_valid && pkt_err)
        chk("valid_and_err", 32'd1, 32'd0);
      if (pkt_valid || pkt_err) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {pkt_valid, pkt_err}, 32'd0);
        end else begin
          ce = evq.pop_front();
          chk("pulse_kind", 32'(pkt_err), 32'(ce.is_err));
          if (!ce.is_err) begin
            exp_reg[ce.sel] = ce.data;
            exp_sel = ce.sel;
          end
        end
      end
      chk("dsky_verb", 32'(dsky_verb), 32'(exp_reg[0]));
      chk("dsky_noun", 32'(dsky_noun), 32'(exp_reg[1]));
      chk("axi_g", 32'(axi_g), 32'(exp_reg[2]));
      chk("axi_m", 32'(axi_m), 32'(exp_reg[3]));
      chk("axi_ra", 32'(axi_ra), 32'(exp_reg[4]));
      chk("axi_rb", 32'(axi_rb), 32'(exp_reg[5]));
      chk("axi_atx", 32'(axi_atx), 32'(exp_reg[6]));
      chk("pkt_sel", 32'(pkt_sel), 32'(exp_sel));
      if (rx_busy) busy_seen = 1;
    end
  end

  task automatic send_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop = 1);
    model_byte(b, stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx_serial = 1'b1;
  endtask

  task automatic send5(input logic [7:0] a, b, c, d, e);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
    send_byte(e);
  endtask

  task automatic idle(input int nbits);
    rx_serial = 1'b1;
    repeat (nbits * CPB) @(negedge clock);
  endtask

  task automatic drain(input string name);
    int t = 0;
    idle(3);
    while (evq.size() != 0 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk(name, evq.size(), 32'd0);
  endtask

  task automatic zero_outputs(input string name);
    chk({name, "_regs"},
        32'(dsky_verb | dsky_noun | axi_g | axi_m |
            axi_ra | axi_rb | axi_atx), 32'd0);
    chk({name, "_flags"},
        {28'd0, pkt_valid, pkt_err, rx_busy, |pkt_sel}, 32'd0);
  endtask

  int v0, e0;

  initial begin
    for (int i = 0; i < 7; i++) exp_reg[i] = 15'd0;
    repeat (4) @(posedge clock);
    #1;
    zero_outputs("reset");
    @(posedge clock);
    #1 reset = 1'b0;
    idle(2);

    // 1: VERB = 37
    v0 = n_valid; e0 = n_err;
    send5(8'hA5, 8'h00, 8'h00, 8'h25, 8'h25);
    drain("t1_drain");
    chk("t1_verb", 32'(dsky_verb), 32'd37);
    chk("t1_sel", 32'(pkt_sel), 32'd0);
    chk("t1_nvalid", n_valid - v0, 32'd1);

    // 2: back-to-back packets
    v0 = n_valid; e0 = n_err;
    send5(8'hA5, 8'h02, 8'h14, 8'h83, 8'h95);
    send5(8'hA5, 8'h01, 8'h00, 8'h05, 8'h04);
    drain("t2_drain");
    chk("t2_g", 32'(axi_g), 32'h1483);
    chk("t2_noun", 32'(dsky_noun), 32'd5);
    chk("t2_nvalid", n_valid - v0, 32'd2);
    chk("t2_nerr", n_err - e0, 32'd0);

    // 3: bad checksum, then 03^12^34 = 25
    v0 = n_valid; e0 = n_err;
    send5(8'hA5, 8'h03, 8'h12, 8'h34, 8'h00);
    drain("t3a_drain");
    chk("t3_nerr", n_err - e0, 32'd1);
    chk("t3_m_hold", 32'(axi_m), 32'd0);
    send5(8'hA5, 8'h03, 8'h12, 8'h34, 8'h25);
    drain("t3b_drain");
    chk("t3_m", 32'(axi_m), 32'h1234);

    // 4: bad select, bad HI bit7
    v0 = n_valid; e0 = n_err;
    send5(8'hA5, 8'h07, 8'h00, 8'h01, 8'h06);
    drain("t4a_drain");
    chk("t4_sel_err", n_err - e0, 32'd1);
    send5(8'hA5, 8'h04, 8'h80, 8'h00, 8'h84);
    drain("t4b_drain");
    chk("t4_hi_err", n_err - e0, 32'd2);
    chk("t4_nvalid", n_valid - v0, 32'd0);
    chk("t4_ra", 32'(axi_ra), 32'd0);

    // 5: framing error mid-packet
    v0 = n_valid; e0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h3C, 1'b0);
    idle(4);
    send5(8'hA5, 8'h05, 8'h7F, 8'hFF, 8'h85);
    drain("t5_drain");
    chk("t5_nerr", n_err - e0, 32'd1);
    chk("t5_rb", 32'(axi_rb), 32'h7FFF);

    // 6: reset during the LO byte
    send_byte(8'hA5);
    send_byte(8'h06);
    send_byte(8'h01);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    zero_outputs("t6_reset");
    mbuf.delete();
    evq.delete();
    for (int i = 0; i < 7; i++) exp_reg[i] = 15'd0;
    exp_sel = 3'd0;
    @(posedge clock);
    #1 reset = 1'b0;
    idle(3);
    v0 = n_valid; e0 = n_err;
    send_byte(8'h05);
    idle(2);
    send5(8'hA5, 8'h06, 8'h01, 8'h02, 8'h05);
    drain("t6_drain");
    chk("t6_atx", 32'(axi_atx), 32'h0102);
    chk("t6_verb", 32'(dsky_verb), 32'd0);
    chk("t6_nvalid", n_valid - v0, 32'd1);
    chk("t6_nerr", n_err - e0, 32'd0);

    // 7: one-cycle glitch on the idle line
    idle(2);
    v0 = n_valid; e0 = n_err;
    busy_seen = 0;
    rx_serial = 1'b0;
    @(negedge clock);
    rx_serial = 1'b1;
    repeat (8) @(negedge clock);
    chk("t7_busy_seen", 32'(busy_seen), 32'd1);
    chk("t7_busy_low", 32'(rx_busy), 32'd0);
    idle(12);
    chk("t7_nvalid", n_valid - v0, 32'd0);
    chk("t7_nerr", n_err - e0, 32'd0);

    // Random packets and noise
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [7:0] s, h, l, c;
      r = $urandom_range(0, 10);
      s = 8'($urandom_range(0, 6));
      h = 8'($urandom_range(0, 127));
      l = 8'($urandom_range(0, 255));
      c = s ^ h ^ l;
      if (r == 6) c = c ^ 8'($urandom_range(1, 255));
      if (r == 7) begin
        s = 8'($urandom_range(7, 255));
        c = s ^ h ^ l;
      end
      if (r == 9) h = h | 8'h80;
      if (r == 8) begin
        send_byte(8'($urandom_range(0, 255)));
      end else if (r == 10) begin
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        idle(3);
      end else begin
        send5(8'hA5, s, h, l, c);
      end
      idle($urandom_range(0, 2));
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
